// File: rtl/control_cb_config_loader.sv
// Serial config loader for a connection-block select bus. Loads commit at the sampling edge.
// No backpressure: one bit is shifted in per cfg_en cycle. Out-of-range selects never reach c.
module control_cb_config_loader #(
    parameter int W          = 8,
    parameter int CONTROLIN  = 6,
    parameter int SEL_PER_IN = $clog2(W*2),
    localparam int CFG_BITS  = SEL_PER_IN*CONTROLIN
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_en,
    input  logic                cfg_in,
    output logic                cfg_out,
    input  logic                cfg_load,
    output logic [CFG_BITS-1:0] c,
    output logic                cfg_valid,
    output logic                cfg_err
);

    localparam int CNT_W = $clog2(CFG_BITS+1);
    localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(CFG_BITS);
    localparam logic [SEL_PER_IN:0]   MUX_IN   = (SEL_PER_IN+1)'(2*W);

    typedef enum logic [1:0] {S_IDLE, S_SHIFTING, S_FULL} state_t;

    state_t              r_state, w_state_shift, w_state_next;
    logic [CFG_BITS-1:0] r_sr, w_sr_shift;
    logic [CNT_W-1:0]    r_count, w_cnt_shift, w_cnt_next;
    logic [CFG_BITS-1:0] r_c, w_c_next;
    logic                r_valid, w_valid_next;
    logic                r_err, w_err_next;
    logic                w_field_bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sr    <= '0;
            r_count <= '0;
            r_c     <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_sr    <= w_sr_shift;
            r_count <= w_cnt_next;
            r_c     <= w_c_next;
            r_valid <= w_valid_next;
            r_err   <= w_err_next;
        end
    end

    // Commit decisions look at the post-shift view so a shift+load cycle includes the new bit.
    always_comb begin
        w_sr_shift    = r_sr;
        w_cnt_shift   = r_count;
        w_state_shift = r_state;
        if (cfg_en) begin
            w_sr_shift = {cfg_in, r_sr[CFG_BITS-1:1]};
            if (r_count != CNT_FULL) begin
                w_cnt_shift = r_count + CNT_W'(1);
            end
            case (r_state)
                S_IDLE, S_SHIFTING:
                    w_state_shift = (w_cnt_shift == CNT_FULL) ? S_FULL : S_SHIFTING;
                default:
                    w_state_shift = S_FULL;
            endcase
        end
    end

    always_comb begin
        w_field_bad = 1'b0;
        for (int i = 0; i < CONTROLIN; i++) begin
            if ({1'b0, w_sr_shift[i*SEL_PER_IN +: SEL_PER_IN]} >= MUX_IN) begin
                w_field_bad = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = w_state_shift;
        w_cnt_next   = w_cnt_shift;
        w_c_next     = r_c;
        w_valid_next = r_valid;
        w_err_next   = r_err;
        if (cfg_load) begin
            case (w_state_shift)
                S_SHIFTING: begin
                    w_err_next   = 1'b1;
                    w_cnt_next   = '0;
                    w_state_next = S_IDLE;
                end
                S_FULL: begin
                    w_cnt_next   = '0;
                    w_state_next = S_IDLE;
                    if (w_field_bad) begin
                        w_err_next = 1'b1;
                    end else begin
                        w_c_next     = w_sr_shift;
                        w_valid_next = 1'b1;
                        w_err_next   = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cfg_out   = r_sr[0];
    assign c         = r_c;
    assign cfg_valid = r_valid;
    assign cfg_err   = r_err;

endmodule
